// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: accepts a DEPTH-bit word on a valid/ready
// handshake and shifts it out MSB-first, one bit per enabled cycle.
module piso_serializer #(
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [DEPTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [DEPTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;

  logic shifting;
  logic at_last;
  logic accept;

  assign shifting = (state_q == SHIFT);
  assign at_last  = (cnt_q == CNT_LAST);

  // Ready on the last-bit cycle too, so a new word follows with no gap.
  assign load_ready = enable && (!shifting || at_last);
  assign accept     = load_valid && load_ready;

  assign dout       = shifting ? sreg_q[DEPTH-1] : 1'b0;
  assign dout_valid = shifting && enable;
  assign first      = dout_valid && (cnt_q == '0);
  assign last       = dout_valid && at_last;
  assign busy       = shifting;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= SHIFT;
      sreg_q  <= load_data;
      cnt_q   <= '0;
    end else if (enable && shifting) begin
      if (at_last) begin
        state_q <= IDLE;
      end else begin
        sreg_q <= {sreg_q[DEPTH-2:0], 1'b0};
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule
